univ_shift_reg_n: RTL and testbench

Parametrised universal shift register: WIDTH-bit storage with hold, logical shift left/right, parallel load, rotate left/right and arithmetic shift right. Adds a multi-cycle "shift by N" command: start/amt launch, busy while running, one-cycle done pulse. Drop-in successor for the 8-bit universal shift register in datapath and serial-conversion blocks. The low two mode bits keep the legacy encoding: 11 load, 10 left, 01 right.

---
 rtl/univ_shift_reg_n.sv | 105 ++++++++++
 tb/tb_univ_shift_reg_n.sv | 131 +++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n: universal shift register with legacy free-running modes and a multi-cycle shift-by-N command.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             CLRb,
    input  logic [2:0]       mode,
    input  logic             SDL,
    input  logic             SDR,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_q, w_q_nx;
    logic [2:0]       r_cmd, w_cmd_nx;
    logic [AMT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             w_shift_mode;
    logic             w_last;

    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic             sdl,
        input logic             sdr
    );
        case (m)
            3'b001:  f_step = {sdr, q[WIDTH-1:1]};
            3'b010:  f_step = {q[WIDTH-2:0], sdl};
            3'b011:  f_step = D;
            3'b100:  f_step = {q[0], q[WIDTH-1:1]};
            3'b101:  f_step = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b110:  f_step = {q[WIDTH-1], q[WIDTH-1:1]};
            default: f_step = q;
        endcase
    endfunction

    // Only the five true shift/rotate modes can run as a multi-cycle command.
    assign w_shift_mode = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100) ||
                          (mode == 3'b101) || (mode == 3'b110);
    assign w_last       = (r_cnt == AMT_W'(1));

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_cmd_nx   = r_cmd;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        if (r_state == RUN) begin
            w_q_nx   = f_step(r_cmd, r_q, SDL, SDR);
            w_cnt_nx = w_last ? r_cnt : r_cnt - AMT_W'(1);
            if (w_last) begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
                w_done_nx  = 1'b1;
            end
        end else if (start) begin
            if (w_shift_mode && |amt) begin
                w_state_nx = RUN;
                w_cmd_nx   = mode;
                w_cnt_nx   = amt;
                w_busy_nx  = 1'b1;
            end else begin
                w_done_nx = 1'b1;
            end
        end else begin
            w_q_nx = f_step(mode, r_q, SDL, SDR);
        end
    end

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cmd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_cmd   <= w_cmd_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign Q    = r_q;
    assign SOL  = r_q[WIDTH-1];
    assign SOR  = r_q[0];
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb_univ_shift_reg_n: directed checks of legacy modes, shift-by-N commands, degenerate starts and async reset.
module tb_univ_shift_reg_n;
    logic       CLK, CLRb, SDL, SDR, start, SOL, SOR, busy, done;
    logic [2:0] mode;
    logic [7:0] D, Q;
    logic [3:0] amt;
    int         tests, fails, n;

    univ_shift_reg_n #(.WIDTH(8), .AMT_W(4)) dut (
        .CLK(CLK), .CLRb(CLRb), .mode(mode), .SDL(SDL), .SDR(SDR), .D(D),
        .start(start), .amt(amt), .Q(Q), .SOL(SOL), .SOR(SOR), .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 3'b011; D = v; start = 1'b0;
        tick();
        mode = 3'b000;
    endtask

    initial begin
        tests = 0; fails = 0;
        CLRb = 1'b0; mode = 3'b000; SDL = 1'b0; SDR = 1'b0; D = 8'h00; start = 1'b0; amt = 4'd0;
        #1;
        chk("rst_q", Q, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        tick();
        CLRb = 1'b1;

        // legacy free-running modes
        mode = 3'b011; D = 8'hA5; tick(); chk("leg_load", Q, 8'hA5);
        mode = 3'b010; SDL = 1'b1; tick(); chk("leg_shl", Q, 8'h4B);
        mode = 3'b001; SDR = 1'b0; tick(); chk("leg_shr", Q, 8'h25);
        mode = 3'b000; tick(); chk("leg_hold", Q, 8'h25);

        // rotate left by 3
        load(8'h81);
        chk("sol_81", SOL, 1'b1);
        chk("sor_81", SOR, 1'b1);
        mode = 3'b101; start = 1'b1; amt = 4'd3; tick();
        start = 1'b0; mode = 3'b000;
        chk("rol_launch_q", Q, 8'h81);
        chk("rol_launch_busy", busy, 1'b1);
        chk("rol_launch_done", done, 1'b0);
        tick(); chk("rol_s1", Q, 8'h03); chk("rol_s1_busy", busy, 1'b1);
        tick(); chk("rol_s2", Q, 8'h06); chk("rol_s2_busy", busy, 1'b1); chk("rol_s2_done", done, 1'b0);
        tick(); chk("rol_s3", Q, 8'h0C); chk("rol_s3_busy", busy, 1'b0); chk("rol_s3_done", done, 1'b1);
        chk("sol_0c", SOL, 1'b0);
        chk("sor_0c", SOR, 1'b0);
        tick(); chk("rol_after_done", done, 1'b0); chk("rol_after_q", Q, 8'h0C);

        // arithmetic right by 2
        load(8'h90);
        mode = 3'b110; start = 1'b1; amt = 4'd2; tick();
        start = 1'b0; mode = 3'b000;
        tick(); chk("asr_s1", Q, 8'hC8);
        tick(); chk("asr_s2", Q, 8'hE4); chk("asr_done", done, 1'b1); chk("asr_busy", busy, 1'b0);

        // arithmetic right by 15 saturates; busy exactly 15 cycles
        load(8'h90);
        mode = 3'b110; start = 1'b1; amt = 4'd15; tick();
        start = 1'b0; mode = 3'b000;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("asr15_busy_cycles", n, 15);
        chk("asr15_q", Q, 8'hFF);
        chk("asr15_done", done, 1'b1);
        tick(); chk("asr15_done_clear", done, 1'b0);

        // degenerate starts: amt=0, and a non-shift mode
        mode = 3'b010; SDL = 1'b0; amt = 4'd0; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000;
        chk("amt0_q", Q, 8'hFF); chk("amt0_busy", busy, 1'b0); chk("amt0_done", done, 1'b1);
        tick(); chk("amt0_done_clear", done, 1'b0);
        mode = 3'b011; D = 8'h00; amt = 4'd5; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000;
        chk("ldcmd_q", Q, 8'hFF); chk("ldcmd_busy", busy, 1'b0); chk("ldcmd_done", done, 1'b1);
        tick(); chk("ldcmd_done_clear", done, 1'b0); chk("ldcmd_q2", Q, 8'hFF);

        // inputs ignored during RUN
        load(8'hF0);
        mode = 3'b001; SDR = 1'b0; amt = 4'd4; start = 1'b1; tick();
        mode = 3'b011; D = 8'hFF; start = 1'b1;
        tick(); chk("ign_s1", Q, 8'h78);
        tick(); chk("ign_s2", Q, 8'h3C);
        tick(); chk("ign_s3", Q, 8'h1E); chk("ign_s3_busy", busy, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk("ign_s4", Q, 8'h0F); chk("ign_done", done, 1'b1); chk("ign_busy", busy, 1'b0);
        chk("sor_0f", SOR, 1'b1);
        tick(); chk("ign_single_done", done, 1'b0); chk("ign_hold", Q, 8'h0F);

        // async reset during the second step of a 6-step shift
        mode = 3'b010; SDL = 1'b1; amt = 4'd6; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000;
        tick(); chk("rst_mid_s1", Q, 8'h1F);
        #2 CLRb = 1'b0;
        #1;
        chk("rst_mid_q", Q, 8'h00); chk("rst_mid_busy", busy, 1'b0); chk("rst_mid_done", done, 1'b0);
        #1 CLRb = 1'b1;
        tick(); chk("rst_rel_done", done, 1'b0); chk("rst_rel_busy", busy, 1'b0); chk("rst_rel_q", Q, 8'h00);
        tick(); chk("rst_rel_done2", done, 1'b0);
        load(8'h01);
        mode = 3'b010; SDL = 1'b0; amt = 4'd2; start = 1'b1; tick();
        start = 1'b0; mode = 3'b000;
        chk("post_busy", busy, 1'b1);
        tick(); chk("post_s1", Q, 8'h02);
        tick(); chk("post_s2", Q, 8'h04); chk("post_done", done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
